// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits
// in the execute stage beside the ALU. When an operation is launched, the unit
// captures its operands. It then holds `busy` for a fixed number of cycles and
// commits the result to HI/LO on the edge where `busy` falls. While the unit is
// idle, mthi/mtlo write the rs operand straight into HI/LO.
//
// Parameters
//   MULT_CYCLES : busy duration of mult/multu (>= 1)
//   DIV_CYCLES  : busy duration of div/divu   (>= 1)
//
// Ports
//   clk      in   1  rising-edge clock
//   reset    in   1  asynchronous active-low reset
//   start    in   1  launch operation md_op on a/b (idle only)
//   md_op    in   2  00 mult, 01 multu, 10 div, 11 divu
//   mthi_we  in   1  HI <- a (idle, no start)
//   mtlo_we  in   1  LO <- a (idle, no start)
//   a        in  32  rs operand
//   b        in  32  rt operand
//   busy     out  1  operation in progress
//   hi       out 32  HI register
//   lo       out 32  LO register
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
    // correct unsigned magnitude of -2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        abs32 = v[31] ? (32'd0 - v) : v;
    endfunction

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic            busy_q, busy_d;
    logic [31:0]     hi_q,   hi_d;
    logic [31:0]     lo_q,   lo_d;
    logic [31:0]     opa_q,  opa_d;
    logic [31:0]     opb_q,  opb_d;
    logic [1:0]      op_q,   op_d;

    logic [63:0] prod_s;
    logic        sgn_s;
    logic [31:0] dvd_mag_s;
    logic [31:0] dvs_mag_s;
    logic [31:0] dvs_safe_s;
    logic [31:0] quo_mag_s;
    logic [31:0] rem_mag_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;
    logic        res_we_s;

    // Result datapath, evaluated on the latched operands only.
    always_comb begin
        // md_op[0] selects unsigned; md_op[1] selects divide.
        sgn_s = ~op_q[0];

        if (sgn_s) begin
            prod_s = $signed({{32{opa_q[31]}}, opa_q}) * $signed({{32{opb_q[31]}}, opb_q});
        end else begin
            prod_s = {32'd0, opa_q} * {32'd0, opb_q};
        end

        dvd_mag_s  = sgn_s ? abs32(opa_q) : opa_q;
        dvs_mag_s  = sgn_s ? abs32(opb_q) : opb_q;
        // A zero divisor produces no write-back; substitute 1 so the divider
        // never sees a zero operand.
        dvs_safe_s = (opb_q == 32'd0) ? 32'd1 : dvs_mag_s;
        quo_mag_s  = dvd_mag_s / dvs_safe_s;
        rem_mag_s  = dvd_mag_s % dvs_safe_s;

        if (op_q[1]) begin
            // Quotient is truncated toward zero. The remainder takes the sign of
            // the dividend. For 0x80000000 / -1 the signs match, so the
            // quotient magnitude 0x80000000 passes through unchanged.
            res_lo_s = (sgn_s && (opa_q[31] ^ opb_q[31])) ? (32'd0 - quo_mag_s) : quo_mag_s;
            res_hi_s = (sgn_s && opa_q[31]) ? (32'd0 - rem_mag_s) : rem_mag_s;
            res_we_s = (opb_q != 32'd0);
        end else begin
            res_lo_s = prod_s[31:0];
            res_hi_s = prod_s[63:32];
            res_we_s = 1'b1;
        end
    end

    // Next-state logic: launch, countdown, commit and idle-time HI/LO moves.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        op_d    = op_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // start takes priority over a same-cycle mthi/mtlo.
                    opa_d   = a;
                    opb_d   = b;
                    op_d    = md_op;
                    cnt_d   = md_op[1] ? DIV_LOAD : MULT_LOAD;
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end else begin
                    if (mthi_we) begin
                        hi_d = a;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (mtlo_we) begin
                        lo_d = a;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    if (res_we_s) begin
                        hi_d = res_hi_s;
                        lo_d = res_lo_s;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, operand latches and architectural HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Self-checking bench for mult_div_unit. A behavioural model of HI/LO
// produces the expected values. These are queued when stimulus is driven and
// are popped and compared when the unit presents its result. Inputs change on
// the falling edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_errors;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] exp_q[$];

    mult_div_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .mthi_we(mthi_we),
        .mtlo_we(mtlo_we),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one operation on the HI/LO model.
    task automatic model_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      sp;
        logic [63:0] up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            2'b00: begin
                sp = sx * sy;
                {m_hi, m_lo} = sp;
            end
            2'b01: begin
                up = {32'd0, x} * {32'd0, y};
                {m_hi, m_lo} = up;
            end
            2'b10: begin
                if (y != 32'd0) begin
                    m_lo = 32'(sx / sy);
                    m_hi = 32'(sx % sy);
                end
            end
            default: begin
                if (y != 32'd0) begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
        endcase
    endtask

    // One-cycle mthi/mtlo write, checked right after its sampling edge.
    task automatic do_mt(input logic whi, input logic wlo, input logic [31:0] val, input string tag);
        logic [63:0] e;
        if (whi) m_hi = val;
        if (wlo) m_lo = val;
        exp_q.push_back({m_hi, m_lo});
        mthi_we = whi;
        mtlo_we = wlo;
        a       = val;
        @(negedge clk);
        mthi_we = 1'b0;
        mtlo_we = 1'b0;
        e = exp_q.pop_front();
        check_value({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
        check_value({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
    endtask

    // Launch an operation, measure the busy width, then check the commit.
    // When disturb is set, a start and an mthi are injected during RUN.
    task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int n, input logic disturb, input string tag);
        logic [63:0] prev;
        logic [63:0] e;
        int          cnt;
        prev = {m_hi, m_lo};
        model_op(op, x, y);
        exp_q.push_back({m_hi, m_lo});
        start = 1'b1;
        md_op = op;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        cnt   = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 1) begin
                check_value({tag, "_hold"}, {hi, lo}, prev);
            end
            if (disturb && cnt == 2) begin
                start = 1'b1;
                md_op = 2'b11;
                a     = 32'd9;
                b     = 32'd4;
            end
            if (disturb && cnt == 3) begin
                start   = 1'b0;
                mthi_we = 1'b1;
                a       = 32'h0000_DEAD;
            end
            if (disturb && cnt == 4) begin
                mthi_we = 1'b0;
            end
            @(negedge clk);
        end
        start   = 1'b0;
        mthi_we = 1'b0;
        check_value({tag, "_busy_width"}, 64'(cnt), 64'(n));
        e = exp_q.pop_front();
        check_value({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
        check_value({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_hi     = 32'd0;
        m_lo     = 32'd0;
        reset    = 1'b0;
        start    = 1'b0;
        md_op    = 2'b00;
        mthi_we  = 1'b0;
        mtlo_we  = 1'b0;
        a        = 32'd0;
        b        = 32'd0;

        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_value("reset_busy", {63'd0, busy}, 64'd0);
        check_value("reset_hi",   {32'd0, hi},   64'd0);
        check_value("reset_lo",   {32'd0, lo},   64'd0);

        do_mt(1'b0, 1'b1, 32'h1234_5678, "mtlo");
        do_mt(1'b1, 1'b0, 32'h9ABC_DEF0, "mthi");

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_N, 1'b0, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         MULT_N, 1'b0, "mult_neg");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         DIV_N,  1'b0, "div_neg");
        run_op(2'b11, 32'd7,         32'd2,         DIV_N,  1'b0, "divu");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N,  1'b0, "div_ovf");
        run_op(2'b10, 32'h0000_0064, 32'hFFFF_FFF9, DIV_N,  1'b0, "div_posneg");

        do_mt(1'b1, 1'b1, 32'h0000_AAAA, "mt_both");
        do_mt(1'b0, 1'b1, 32'h0000_5555, "preload_lo");
        run_op(2'b10, 32'd5, 32'd0, DIV_N, 1'b0, "div_by0");
        run_op(2'b11, 32'd5, 32'd0, DIV_N, 1'b0, "divu_by0");

        run_op(2'b00, 32'd2, 32'd3, MULT_N, 1'b1, "mult_ignore");

        // Abort a division with an asynchronous reset in the middle of a cycle.
        do_mt(1'b1, 1'b0, 32'h0000_1111, "pre_abort");
        start = 1'b1;
        md_op = 2'b10;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_value("abort_busy", {63'd0, busy}, 64'd0);
        check_value("abort_hi",   {32'd0, hi},   64'd0);
        check_value("abort_lo",   {32'd0, lo},   64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        run_op(2'b00, 32'd4, 32'd4, MULT_N, 1'b0, "mult_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
